mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Accepts one EX result per handshake and performs the load/store on a variable-latency data-RAM bus with byte-lane enables.
- Checks alignment and produces load data with sign or zero extension, then presents a registered result to write-back.
- Stalls the upstream pipeline while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32: address width; the EX result is used as the effective address.
- DATA_W, 32: data width; must be 32.
- TIMEOUT, 255: maximum wait cycles for ram_ack before a bus error is raised; 8-bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  EX output is valid this cycle
- in_ready  out  1  stage can accept; in_ready = (state==IDLE)
- flush  in  1  exception flush; kills any uncommitted op
- ex_result  in  32  ALU result or effective address
- mem_read  in  1  load
- mem_write  in  1  store
- mem_sign_ext  in  1  sign-extend load data
- mem_sel  in  4  size mask: 0001 byte, 0011 half, 1111 word
- mem_wdata  in  32  store data, right-aligned
- reg_we_in  in  1  register write enable
- reg_waddr_in  in  5  destination register
- pc_in  in  32  instruction PC
- ram_en  out  1  bus request
- ram_we  out  4  byte write enables; 0 for a load
- ram_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  read data
- ram_ack  in  1  transaction complete
- stall_req  out  1  = in_valid && !in_ready
- wb_valid  out  1  one-cycle pulse per completed op
- wb_data  out  32  load data or pass-through result
- wb_reg_we  out  1  register write enable
- wb_reg_waddr  out  5  destination register
- wb_pc  out  32  instruction PC
- adel  out  1  load address error
- ades  out  1  store address error
- bus_err  out  1  bus timeout
- bad_vaddr  out  32  faulting address

Behaviour:
- Reset (async, rst_n=0): state=IDLE. ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, wb_valid=0, wb_data=0, wb_reg_we=0, wb_reg_waddr=0, wb_pc=0, adel=ades=bus_err=0, bad_vaddr=0, timeout counter=0.
- States: IDLE, BUS.
- Accept = in_valid && in_ready && !flush. All inputs are captured on the accept edge.
- Non-memory op (mem_read=mem_write=0): next cycle wb_valid=1, wb_data=ex_result, wb_reg_we=reg_we_in. State stays IDLE.
- Alignment check:
  - Half access faults if addr[0]!=0.
  - Word access faults if addr[1:0]!=0.
  - A fault issues no bus request. Next cycle: wb_valid=1, adel (load) or ades (store), bad_vaddr=ex_result, wb_reg_we=0.
- Aligned memory op: register ram_en=1, ram_addr, ram_we, ram_wdata; go to BUS.
  - Store: ram_we = mem_sel << addr[1:0].
  - ram_wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- BUS state:
  - Bus outputs hold stable until ram_ack. The counter increments each cycle ram_ack=0.
  - On ram_ack: ram_en=0, ram_we=0, return to IDLE; next cycle wb_valid=1.
  - Load data: shift ram_rdata right by 8*addr[1:0], then keep 8/16/32 bits and extend per mem_sign_ext. wb_reg_we=reg_we_in for loads, 0 for stores.
  - Latency: with ram_ack in the first BUS cycle, wb_valid rises 2 cycles after accept.
- Timeout: if the counter reaches TIMEOUT without ram_ack, drop ram_en and return to IDLE. Next cycle: wb_valid=1, bus_err=1, bad_vaddr=addr, wb_reg_we=0.
- Flush:
  - In IDLE: no accept that cycle.
  - In BUS: the bus transaction still completes (no abort), but its wb_valid is suppressed.
  - A flush coinciding with a wb_valid output cycle does not retract that output.
- Simultaneous ram_ack and timeout expiry: ack wins.
- Exception flags and wb_valid are single-cycle pulses; the other wb_* registers hold until the next completion.
- ram_ack outside BUS is ignored.

Decomposition:
- Shared package/header:
  - MEM_SEL encodings (BYTE=0001, HALF=0011, WORD=1111)
  - state encodings
  - TIMEOUT default
  - widths taken from the existing bus definitions
- One natural sub-module, mem_load_align: combinational rdata shift, mask and extend, so it can be unit-tested separately.

Test Plan:
- Pass-through: ADDU result 0x0000_1234, reg_we=1 -> next cycle wb_valid=1, wb_data=0x1234, no ram_en.
- Byte load, sign-extended: addr 0x1003, rdata 0x80FF_FF7F... byte lane 3 = 0x80, ack after 3 wait cycles -> wb_data=0xFFFF_FF80; stall_req high while busy; wb_valid 5 cycles after accept.
- Half store: addr 0x2002, wdata 0x0000_BEEF -> ram_we=1100, ram_wdata=0xBEEF_BEEF, ram_addr=0x2000, wb_reg_we=0.
- Misaligned word load at 0x3001 -> no ram_en; adel=1, bad_vaddr=0x3001, wb_reg_we=0.
- Flush during BUS: ram_en held until ack, then no wb_valid; next accepted op proceeds normally.
- Timeout: ram_ack never asserted -> ram_en drops after 255 cycles, bus_err pulse; assert rst_n=0 mid-BUS in a second run -> ram_en=0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and helpers for the memory-access stage: size masks,
// FSM states, bus widths and the store-data lane replication.
package mem_access_stage_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_W      = 4;
  localparam int REG_W      = 5;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [SEL_W-1:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [SEL_W-1:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [SEL_W-1:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  // Unknown size masks are checked as strictly as a word access.
  function automatic logic misaligned(input logic [SEL_W-1:0] sel, input logic [1:0] lo);
    case (sel)
      MEM_SEL_BYTE: return 1'b0;
      MEM_SEL_HALF: return lo[0];
      default:      return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [SEL_W-1:0] sel, input logic [31:0] d);
    case (sel)
      MEM_SEL_BYTE: return {4{d[7:0]}};
      MEM_SEL_HALF: return {2{d[15:0]}};
      default:      return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load-data alignment: shift the addressed lane down, keep 8/16/32 bits
// and sign- or zero-extend the result.
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0]      rdata_i,
  input  logic [1:0]       byte_off_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             sign_ext_i,
  output logic [31:0]      data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {byte_off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (sel_i)
      MEM_SEL_BYTE: data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
      MEM_SEL_HALF: data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      default:      data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: accepts one EX result, runs the load/store on a
// variable-latency RAM bus and hands a registered result to write-back.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ex_result,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_sign_ext,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              reg_we_in,
  input  logic [REG_W-1:0]  reg_waddr_in,
  input  logic [31:0]       pc_in,
  output logic              ram_en,
  output logic [SEL_W-1:0]  ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              stall_req,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_we,
  output logic [REG_W-1:0]  wb_reg_waddr,
  output logic [31:0]       wb_pc,
  output logic              adel,
  output logic              ades,
  output logic              bus_err,
  output logic [ADDR_W-1:0] bad_vaddr
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               is_load_q, sign_q, reg_we_q, kill_q;
  logic [SEL_W-1:0]   sel_q;
  logic [REG_W-1:0]   waddr_q;
  logic [31:0]        pc_q;
  logic               ram_en_q, wb_valid_q, wb_reg_we_q, adel_q, ades_q, bus_err_q;
  logic [SEL_W-1:0]   ram_we_q;
  logic [ADDR_W-1:0]  ram_addr_q, bad_vaddr_q;
  logic [DATA_W-1:0]  ram_wdata_q, wb_data_q;
  logic [REG_W-1:0]   wb_reg_waddr_q;
  logic [31:0]        wb_pc_q;
  logic [31:0]        load_data;
  logic               accept, is_mem, is_store, bad_align, drop;

  assign in_ready  = (state_q == ST_IDLE);
  assign stall_req = in_valid && !in_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign is_mem    = mem_read || mem_write;
  assign is_store  = mem_write && !mem_read;
  assign bad_align = misaligned(mem_sel, ex_result[1:0]);
  // A flush anywhere during the transaction, including its last cycle, kills the result.
  assign drop      = kill_q || flush;

  mem_load_align u_align (
    .rdata_i    (ram_rdata),
    .byte_off_i (addr_q[1:0]),
    .sel_i      (sel_q),
    .sign_ext_i (sign_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  cnt_q <= '0;  addr_q <= '0;  sel_q <= '0;
      is_load_q <= 1'b0;  sign_q <= 1'b0;  reg_we_q <= 1'b0;  kill_q <= 1'b0;
      waddr_q <= '0;  pc_q <= '0;
      ram_en_q <= 1'b0;  ram_we_q <= '0;  ram_addr_q <= '0;  ram_wdata_q <= '0;
      wb_valid_q <= 1'b0;  wb_data_q <= '0;  wb_reg_we_q <= 1'b0;
      wb_reg_waddr_q <= '0;  wb_pc_q <= '0;
      adel_q <= 1'b0;  ades_q <= 1'b0;  bus_err_q <= 1'b0;  bad_vaddr_q <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          if (!is_mem) begin
            wb_valid_q     <= 1'b1;
            wb_data_q      <= ex_result;
            wb_reg_we_q    <= reg_we_in;
            wb_reg_waddr_q <= reg_waddr_in;
            wb_pc_q        <= pc_in;
          end else if (bad_align) begin
            wb_valid_q     <= 1'b1;
            adel_q         <= mem_read;
            ades_q         <= is_store;
            bad_vaddr_q    <= ex_result;
            wb_reg_we_q    <= 1'b0;
            wb_reg_waddr_q <= reg_waddr_in;
            wb_pc_q        <= pc_in;
          end else begin
            ram_en_q    <= 1'b1;
            ram_addr_q  <= {ex_result[ADDR_W-1:2], 2'b00};
            ram_we_q    <= is_store ? SEL_W'(mem_sel << ex_result[1:0]) : '0;
            ram_wdata_q <= replicate(mem_sel, mem_wdata);
            addr_q      <= ex_result;
            sel_q       <= mem_sel;
            is_load_q   <= mem_read;
            sign_q      <= mem_sign_ext;
            reg_we_q    <= reg_we_in;
            waddr_q     <= reg_waddr_in;
            pc_q        <= pc_in;
            kill_q      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (flush) kill_q <= 1'b1;
          if (ram_ack || cnt_q == CNT_LAST) begin
            ram_en_q <= 1'b0;
            ram_we_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            if (!drop) begin
              wb_valid_q     <= 1'b1;
              wb_reg_waddr_q <= waddr_q;
              wb_pc_q        <= pc_q;
              if (ram_ack) begin
                wb_data_q   <= is_load_q ? load_data : addr_q;
                wb_reg_we_q <= is_load_q && reg_we_q;
              end else begin
                bus_err_q   <= 1'b1;
                bad_vaddr_q <= addr_q;
                wb_reg_we_q <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_reg_we    = wb_reg_we_q;
  assign wb_reg_waddr = wb_reg_waddr_q;
  assign wb_pc        = wb_pc_q;
  assign adel         = adel_q;
  assign ades         = ades_q;
  assign bus_err      = bus_err_q;
  assign bad_vaddr    = bad_vaddr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, loads, stores,
// alignment faults, flush, timeout and asynchronous reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic [31:0] ex_result;
  logic        mem_read, mem_write, mem_sign_ext;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic        reg_we_in;
  logic [4:0]  reg_waddr_in;
  logic [31:0] pc_in;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack, stall_req, wb_valid;
  logic [31:0] wb_data;
  logic        wb_reg_we;
  logic [4:0]  wb_reg_waddr;
  logic [31:0] wb_pc;
  logic        adel, ades, bus_err;
  logic [31:0] bad_vaddr;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .ex_result(ex_result), .mem_read(mem_read), .mem_write(mem_write),
    .mem_sign_ext(mem_sign_ext), .mem_sel(mem_sel), .mem_wdata(mem_wdata),
    .reg_we_in(reg_we_in), .reg_waddr_in(reg_waddr_in), .pc_in(pc_in),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .stall_req(stall_req),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg_we(wb_reg_we),
    .wb_reg_waddr(wb_reg_waddr), .wb_pc(wb_pc), .adel(adel), .ades(ades),
    .bus_err(bus_err), .bad_vaddr(bad_vaddr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one accepting edge.
  task automatic issue(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd, input logic we,
                       input logic [4:0] wa, input logic [31:0] pc);
    mem_read = rd;  mem_write = wr;  mem_sign_ext = sx;  mem_sel = sel;
    ex_result = addr;  mem_wdata = wd;  reg_we_in = we;  reg_waddr_in = wa;  pc_in = pc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;  mem_read = 1'b0;  mem_write = 1'b0;
  endtask

  int n;

  initial begin
    rst_n = 1'b0;  in_valid = 1'b0;  flush = 1'b0;  ex_result = '0;
    mem_read = 1'b0;  mem_write = 1'b0;  mem_sign_ext = 1'b0;  mem_sel = 4'b0000;
    mem_wdata = '0;  reg_we_in = 1'b0;  reg_waddr_in = '0;  pc_in = '0;
    ram_rdata = '0;  ram_ack = 1'b0;
    repeat (2) tick();
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Pass-through ALU result
    issue(0, 0, 0, 4'b0000, 32'h0000_1234, 0, 1, 5'd7, 32'h0000_0100);
    check("pt_wb_valid", 32'(wb_valid), 32'd1);
    check("pt_wb_data", wb_data, 32'h0000_1234);
    check("pt_wb_reg_we", 32'(wb_reg_we), 32'd1);
    check("pt_waddr", 32'(wb_reg_waddr), 32'd7);
    check("pt_pc", wb_pc, 32'h0000_0100);
    check("pt_ram_en", 32'(ram_en), 32'd0);
    tick();
    check("pt_pulse_end", 32'(wb_valid), 32'd0);
    check("pt_data_hold", wb_data, 32'h0000_1234);

    // Sign-extended byte load from lane 3, three wait cycles
    issue(1, 0, 1, 4'b0001, 32'h0000_1003, 0, 1, 5'd3, 32'h0000_0104);
    check("lb_ram_en", 32'(ram_en), 32'd1);
    check("lb_ram_addr", ram_addr, 32'h0000_1000);
    check("lb_ram_we", 32'(ram_we), 32'd0);
    in_valid = 1'b1;
    #1;
    check("lb_stall_req", 32'(stall_req), 32'd1);
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("lb_no_early_wb", 32'(wb_valid), 32'd0);
    ram_ack = 1'b1;  ram_rdata = 32'h80FF_FF7F;
    tick();
    ram_ack = 1'b0;
    check("lb_wb_valid_c5", 32'(wb_valid), 32'd1);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_ram_en_off", 32'(ram_en), 32'd0);
    check("lb_in_ready", 32'(in_ready), 32'd1);

    // Half store at byte offset 2
    issue(0, 1, 0, 4'b0011, 32'h0000_2002, 32'h0000_BEEF, 1, 5'd4, 32'h0000_0108);
    check("sh_ram_we", 32'(ram_we), 32'h0000_000C);
    check("sh_ram_wdata", ram_wdata, 32'hBEEF_BEEF);
    check("sh_ram_addr", ram_addr, 32'h0000_2000);
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    check("sh_wb_valid", 32'(wb_valid), 32'd1);
    check("sh_wb_reg_we", 32'(wb_reg_we), 32'd0);

    // Zero-extended half load, ack in first bus cycle
    issue(1, 0, 0, 4'b0011, 32'h0000_5002, 0, 1, 5'd9, 32'h0000_010C);
    ram_ack = 1'b1;  ram_rdata = 32'h8001_1234;
    tick();
    ram_ack = 1'b0;
    check("lhu_wb_valid_c2", 32'(wb_valid), 32'd1);
    check("lhu_wb_data", wb_data, 32'h0000_8001);
    check("lhu_waddr", 32'(wb_reg_waddr), 32'd9);

    // Misaligned word load
    issue(1, 0, 0, 4'b1111, 32'h0000_3001, 0, 1, 5'd5, 32'h0000_0110);
    check("adel_ram_en", 32'(ram_en), 32'd0);
    check("adel_flag", 32'(adel), 32'd1);
    check("adel_ades", 32'(ades), 32'd0);
    check("adel_vaddr", bad_vaddr, 32'h0000_3001);
    check("adel_reg_we", 32'(wb_reg_we), 32'd0);
    check("adel_wb_valid", 32'(wb_valid), 32'd1);
    tick();
    check("adel_pulse_end", 32'(adel), 32'd0);

    // Misaligned half store
    issue(0, 1, 0, 4'b0011, 32'h0000_4001, 32'h1, 0, 5'd0, 32'h0000_0114);
    check("ades_flag", 32'(ades), 32'd1);
    check("ades_vaddr", bad_vaddr, 32'h0000_4001);

    // Flush in IDLE blocks the accept
    flush = 1'b1;
    issue(0, 0, 0, 4'b0000, 32'h0000_0AAA, 0, 1, 5'd1, 32'h0000_0118);
    flush = 1'b0;
    check("flush_idle_wb", 32'(wb_valid), 32'd0);

    // Flush during BUS: bus completes, result suppressed
    issue(1, 0, 0, 4'b1111, 32'h0000_6000, 0, 1, 5'd6, 32'h0000_011C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("flush_bus_held", 32'(ram_en), 32'd1);
    ram_ack = 1'b1;  ram_rdata = 32'h1234_5678;
    tick();
    ram_ack = 1'b0;
    check("flush_bus_no_wb", 32'(wb_valid), 32'd0);
    check("flush_bus_en_off", 32'(ram_en), 32'd0);
    issue(0, 0, 0, 4'b0000, 32'h0000_0BBB, 0, 1, 5'd2, 32'h0000_0120);
    check("post_flush_wb", 32'(wb_valid), 32'd1);
    check("post_flush_data", wb_data, 32'h0000_0BBB);

    // Timeout: no ack ever
    issue(1, 0, 0, 4'b1111, 32'h0000_7000, 0, 1, 5'd8, 32'h0000_0124);
    n = 0;
    while (ram_en === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    check("to_en_cycles", 32'(n), 32'd255);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_wb_valid", 32'(wb_valid), 32'd1);
    check("to_vaddr", bad_vaddr, 32'h0000_7000);
    check("to_reg_we", 32'(wb_reg_we), 32'd0);

    // Ack in the very cycle the timeout would expire: ack wins
    issue(1, 0, 0, 4'b1111, 32'h0000_7100, 0, 1, 5'd8, 32'h0000_0128);
    repeat (254) tick();
    ram_ack = 1'b1;  ram_rdata = 32'h1111_2222;
    tick();
    ram_ack = 1'b0;
    check("ackwin_bus_err", 32'(bus_err), 32'd0);
    check("ackwin_wb_data", wb_data, 32'h1111_2222);

    // Asynchronous reset mid-BUS
    issue(1, 0, 0, 4'b1111, 32'h0000_8000, 0, 1, 5'd10, 32'h0000_012C);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_ram_en", 32'(ram_en), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
